// File: rtl/spi_master_cfg_if.sv
// Host-side control and SPI pin bundle for spi_master_cfg.
// The master modport is the controller's view; slave is the environment's view.
interface spi_master_cfg_if #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 1,
   parameter int DIV_W  = 16
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

   logic              start;
   logic              cpol;
   logic              cpha;
   logic              lsb_first;
   logic [DIV_W-1:0]  clk_div;
   logic [CS_W-1:0]   cs_sel;
   logic [DATA_W-1:0] tx_data;
   logic [DATA_W-1:0] rx_data;
   logic              rx_valid;
   logic              busy;
   logic              sclk;
   logic              mosi;
   logic              miso;
   logic [NUM_CS-1:0] cs_n;

   modport master (
      input  start, cpol, cpha, lsb_first, clk_div, cs_sel, tx_data, miso,
      output rx_data, rx_valid, busy, sclk, mosi, cs_n
   );

   modport slave (
      output start, cpol, cpha, lsb_first, clk_div, cs_sel, tx_data, miso,
      input  rx_data, rx_valid, busy, sclk, mosi, cs_n
   );
endinterface

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: one full-duplex word per start, CPOL/CPHA modes,
// MSB/LSB order, runtime SCLK divider and one-hot-low chip selects.
module spi_master_cfg #(
   parameter int DATA_W = 8,
   parameter int NUM_CS = 1,
   parameter int DIV_W  = 16
) (
   input  logic clk,
   input  logic reset_n,
   spi_master_cfg_if.master bus
);
   localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
   localparam int EC_W = $clog2(2*DATA_W + 2);

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_e;

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [EC_W-1:0]   ecnt_q, ecnt_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic              lsb_q, lsb_d;
   logic [DATA_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic              busy_q, busy_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic [NUM_CS-1:0] cs_n_q, cs_n_d;
   logic              tick, cs_ok, last_edge;

   // cnt never exceeds the latched divider, so an all-ones divider cannot wrap
   assign tick      = (cnt_q == div_q);
   assign cs_ok     = ({1'b0, bus.cs_sel} < (CS_W+1)'(NUM_CS));
   assign last_edge = (ecnt_q == EC_W'(2*DATA_W - 1));

   always_comb begin
      state_d    = state_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      ecnt_d     = ecnt_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      lsb_d      = lsb_q;
      tx_d       = tx_q;
      rx_sh_d    = rx_sh_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      busy_d     = busy_q;
      sclk_d     = sclk_q;
      mosi_d     = mosi_q;
      cs_n_d     = cs_n_q;
      case (state_q)
         IDLE: begin
            if (bus.start && cs_ok) begin
               state_d = LEAD;
               div_d   = bus.clk_div;
               cnt_d   = '0;
               ecnt_d  = '0;
               cpol_d  = bus.cpol;
               cpha_d  = bus.cpha;
               lsb_d   = bus.lsb_first;
               rx_sh_d = '0;
               busy_d  = 1'b1;
               sclk_d  = bus.cpol;
               for (int i = 0; i < NUM_CS; i++) cs_n_d[i] = (CS_W'(i) != bus.cs_sel);
               // CPHA=0 must present the first bit before the first (sampling) edge
               if (!bus.cpha) begin
                  mosi_d = bus.lsb_first ? bus.tx_data[0] : bus.tx_data[DATA_W-1];
                  tx_d   = bus.lsb_first ? (bus.tx_data >> 1) : (bus.tx_data << 1);
               end else begin
                  tx_d   = bus.tx_data;
               end
            end
         end
         default: begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) begin
               ecnt_d = ecnt_q + 1'b1;
               if (state_q == TRAIL) begin
                  state_d    = IDLE;
                  busy_d     = 1'b0;
                  cs_n_d     = '1;
                  rx_data_d  = rx_sh_q;
                  rx_valid_d = 1'b1;
               end else begin
                  state_d = last_edge ? TRAIL : SHIFT;
                  sclk_d  = ~sclk_q;
                  // even ecnt is a leading edge; sample edge is leading for CPHA=0
                  if (ecnt_q[0] == cpha_q) begin
                     rx_sh_d = lsb_q ? {bus.miso, rx_sh_q[DATA_W-1:1]}
                                     : {rx_sh_q[DATA_W-2:0], bus.miso};
                  end else if (!last_edge) begin
                     mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
                     tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         div_q      <= '0;
         cnt_q      <= '0;
         ecnt_q     <= '0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         lsb_q      <= 1'b0;
         tx_q       <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         sclk_q     <= 1'b0;
         mosi_q     <= 1'b0;
         cs_n_q     <= '1;
      end else begin
         state_q    <= state_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         ecnt_q     <= ecnt_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         lsb_q      <= lsb_d;
         tx_q       <= tx_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         busy_q     <= busy_d;
         sclk_q     <= sclk_d;
         mosi_q     <= mosi_d;
         cs_n_q     <= cs_n_d;
      end
   end

   assign bus.rx_data  = rx_data_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.busy     = busy_q;
   assign bus.sclk     = sclk_q;
   assign bus.mosi     = mosi_q;
   assign bus.cs_n     = cs_n_q;
endmodule
